// File: rtl/cache_fill_arbiter.sv
// Shares one multi-cycle memory between I-cache fills, D-cache fills and D-side
// write-through stores; a fill streams one 8-word block with pipelined reads.
module cache_fill_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_done,
    output logic              busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WRITE  = 2'd1;
    localparam logic [1:0] FILL_I = 2'd2;
    localparam logic [1:0] FILL_D = 2'd3;
    localparam logic [2:0] LAST   = 3'(WORDS - 1);

    logic [1:0]        state;
    logic [ADDR_W-5:0] base;
    logic [2:0]        iss;
    logic [2:0]        rcv;
    logic              iss_active;

    logic       filling;
    logic       rx;
    logic       iss_go;
    logic [3:0] issued_n;
    logic [3:0] inflight;
    logic       unused_ok;

    assign unused_ok = ^{i_miss_addr[3:0], d_miss_addr[3:0]};

    assign filling  = (state == FILL_I) || (state == FILL_D);
    assign rx       = filling && mem_data_valid;
    assign issued_n = iss_active ? {1'b0, iss} : 4'(WORDS);
    assign inflight = issued_n - {1'b0, rcv};
    // A word returning this cycle frees its slot, so a memory honouring
    // MEM_LAT never stalls issue; a slower one is throttled to MEM_LAT reads.
    assign iss_go   = filling && iss_active &&
                      (inflight < 4'(MEM_LAT) + {3'b0, mem_data_valid});

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base       <= '0;
            iss        <= '0;
            rcv        <= '0;
            iss_active <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_wr) begin
                        state <= WRITE;
                    end else if (d_miss) begin
                        state      <= FILL_D;
                        base       <= d_miss_addr[ADDR_W-1:4];
                        iss_active <= 1'b1;
                    end else if (i_miss) begin
                        state      <= FILL_I;
                        base       <= i_miss_addr[ADDR_W-1:4];
                        iss_active <= 1'b1;
                    end
                end
                WRITE: state <= IDLE;
                default: begin
                    if (iss_go) begin
                        iss <= iss + 3'd1;
                        if (iss == LAST) iss_active <= 1'b0;
                    end
                    if (mem_data_valid) begin
                        rcv <= rcv + 3'd1;
                        if (rcv == LAST) begin
                            state      <= IDLE;
                            iss        <= '0;
                            rcv        <= '0;
                            iss_active <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        mem_enable  = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        fill_data   = '0;
        fill_word   = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_done   = 1'b0;
        busy        = (state != IDLE);
        if (state == WRITE) begin
            mem_enable  = 1'b1;
            mem_wr      = 1'b1;
            mem_addr    = d_wr_addr;
            mem_data_in = d_wr_data;
            d_wr_done   = 1'b1;
        end else if (iss_go) begin
            mem_enable = 1'b1;
            mem_addr   = {base, iss, 1'b0};
        end
        if (rx) begin
            fill_data   = mem_data_out;
            fill_word   = rcv;
            i_fill_we   = (state == FILL_I);
            d_fill_we   = (state == FILL_D);
            i_fill_done = (state == FILL_I) && (rcv == LAST);
            d_fill_done = (state == FILL_D) && (rcv == LAST);
        end
    end
endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Sequencer and arbiter that shares the single multi-cycle main memory between the instruction-cache miss path, the data-cache miss path and data-side write-through stores. It sits between the two cache controllers and the unified memory. On a miss it streams one 16-byte block (8 words) into the requesting cache, pipelining word requests against the memory's fixed read latency. Stores are written through one word at a time.

## Interface
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- WORDS, 8, words per cache block (block = 16 bytes, word address bits [3:1])
- MEM_LAT, 4, cycles from a read issue to its mem_data_valid

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset; the memory shares this reset
- i_miss  in  1  I-cache miss; held high until i_fill_done
- i_miss_addr  in  ADDR_W  missing instruction address; bits [3:0] ignored
- d_miss  in  1  D-cache miss; held high until d_fill_done
- d_miss_addr  in  ADDR_W  missing data address; bits [3:0] ignored
- d_wr  in  1  write-through store request; held high until d_wr_done
- d_wr_addr  in  ADDR_W  store address
- d_wr_data  in  DATA_W  store data
- mem_enable  out  1  memory access this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  write data to memory
- mem_data_out  in  DATA_W  read data from memory
- mem_data_valid  in  1  mem_data_out is valid this cycle
- fill_data  out  DATA_W  word being written into a cache
- fill_word  out  3  word index within the block for fill_data
- i_fill_we  out  1  write fill_data into the I-cache data array
- d_fill_we  out  1  write fill_data into the D-cache data array
- i_fill_done  out  1  one-cycle pulse: I-block complete
- d_fill_done  out  1  one-cycle pulse: D-block complete
- d_wr_done  out  1  one-cycle pulse: store accepted by memory
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WRITE, FILL_I, FILL_D. Reset → IDLE.
- IDLE priority, fixed: d_wr > d_miss > i_miss. Rationale: the data side holds the oldest stalled instruction.
  - d_wr → WRITE.
  - else d_miss → FILL_D, latch base = d_miss_addr[15:4].
  - else i_miss → FILL_I, latch base = i_miss_addr[15:4].
  - A request is sampled only in IDLE. Losing requesters keep waiting with no timeout.
- WRITE, one cycle:
  - mem_enable=1, mem_wr=1, mem_addr=d_wr_addr, mem_data_in=d_wr_data, d_wr_done=1.
  - Next state IDLE.
- FILL_x, issue phase:
  - 3-bit issue counter iss, 0..WORDS-1.
  - While iss_active: mem_enable=1, mem_wr=0, mem_addr={base, iss, 1'b0}, iss++.
  - iss_active clears after word 7 is issued.
- FILL_x, receive phase:
  - 3-bit counter rcv.
  - Each cycle with mem_data_valid: fill_data=mem_data_out (combinational pass-through), fill_word=rcv, the matching x_fill_we=1, rcv++.
  - When rcv==7 and mem_data_valid: x_fill_done=1 that same cycle. Next state IDLE; iss, rcv and iss_active cleared.
- mem_data_valid in IDLE or WRITE is ignored: no we, no counter change.
- A requester deasserting mid-fill does not abort the fill. The block completes and x_fill_done still pulses.
- Idle outputs: all 0. mem_addr and mem_data_in are driven to 0 when mem_enable=0.
- Reset mid-operation returns to IDLE in one cycle with all counters 0. No done pulse; partial block discarded; the requester must re-request.

## Timing
- Reset values: every output 0; busy=0.
- Fill, with grant sampled in IDLE at cycle T:
  - Reads issued T+1..T+8.
  - Data valid T+1+MEM_LAT .. T+8+MEM_LAT.
  - x_fill_done at T+8+MEM_LAT (T+12 at default MEM_LAT).
  - Back in IDLE at T+13.
- Store: grant at T, write and d_wr_done at T+1, IDLE at T+2.
- Back-to-back: the next request is granted in the first IDLE cycle after completion. No arbitration while busy.
- Issue and receive overlap; at most MEM_LAT reads are outstanding.
- Counters wrap naturally at 3 bits; a fill never exceeds WORDS reads or WORDS we pulses.

## Test plan
- Single I-miss: i_miss=1, i_miss_addr=0x1236 at T.
  - Reads 0x1230,0x1232,…,0x123E issued T+1..T+8.
  - i_fill_we with fill_word 0..7 at T+5..T+12.
  - i_fill_done at T+12 only; d_fill_we stays 0.
- Simultaneous requests: d_wr (0x0040←0xBEEF), d_miss 0x2000 and i_miss 0x0100 all high at T.
  - Order: WRITE (mem_wr=1, mem_addr=0x0040, mem_data_in=0xBEEF, d_wr_done at T+1).
  - Then D-fill 0x2000–0x200E, d_fill_done at T+14.
  - Then I-fill 0x0100–0x010E, i_fill_done at T+27.
- Stray valid: mem_data_valid=1 with mem_data_out=0x1111 while IDLE.
  - No fill_we, no done, fill_word stays 0.
- Requester drop: i_miss deasserted at T+3 of an I-fill.
  - All 8 words are still written and i_fill_done pulses at T+12.
- Reset mid-fill: rst=1 at T+6 of a D-fill.
  - Next cycle all outputs 0 and busy=0.
  - Re-request at T+8 restarts from word 0 with done 12 cycles after the grant.
- Store during fill: d_wr raised at T+2 of an I-fill.
  - d_wr is not serviced until IDLE.
  - WRITE issues at T+14; d_wr_done at T+14.
